// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for a convolutional encoder / Viterbi decoder loop-back.
// Streams FRAME_LEN payload bits and then TAIL_LEN zero flush bits into the
// encoder. Each payload bit is compared with the decoder output DEC_LAT cycles
// later, and the number of mismatches is counted.
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned TAIL_LEN  = 2,
  parameter int unsigned DEC_LAT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        in_valid_i,
  input  logic        in_data_i,
  output logic        in_ready_o,
  output logic        enc_bit_o,
  output logic        enc_en_o,
  input  logic        dec_bit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned PAY_W   = $clog2(FRAME_LEN + 1);
  localparam int unsigned AUX_MAX = (DEC_LAT > TAIL_LEN) ? DEC_LAT : TAIL_LEN;
  localparam int unsigned AUX_W   = $clog2(AUX_MAX + 1);
  localparam logic [PAY_W-1:0] PAY_LAST   = PAY_W'(FRAME_LEN - 1);
  localparam logic [AUX_W-1:0] TAIL_LAST  = AUX_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
  localparam logic [AUX_W-1:0] DRAIN_LAST = AUX_W'(DEC_LAT);

  typedef enum logic [2:0] {IDLE, SEND, TAIL, DRAIN, DONE} state_t;

  state_t             state;
  logic [PAY_W-1:0]   pay_cnt;
  logic [AUX_W-1:0]   aux_cnt;   // tail bit counter in TAIL, drain counter in DRAIN
  logic               enc_pay;   // current enc_en_o cycle carries a payload bit
  logic [DEC_LAT-1:0] pipe_vld;
  logic [DEC_LAT-1:0] pipe_bit;
  logic [15:0]        err_cnt;
  logic               xfer;
  logic               mism;

  assign xfer      = in_valid_i & in_ready_o;
  assign mism      = pipe_vld[DEC_LAT-1] & (dec_bit_i != pipe_bit[DEC_LAT-1]);
  assign err_cnt_o = err_cnt;

  // Frame sequencing FSM; all outputs are registered alongside the state.
  // DRAIN is entered on the last enc_en_o cycle and holds for DEC_LAT+1
  // cycles, so DONE always lands DEC_LAT+1 cycles after the final encoder bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pay_cnt    <= '0;
      aux_cnt    <= '0;
      in_ready_o <= 1'b0;
      enc_en_o   <= 1'b0;
      enc_bit_o  <= 1'b0;
      enc_pay    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      enc_en_o  <= 1'b0;
      enc_bit_o <= 1'b0;
      enc_pay   <= 1'b0;
      done_o    <= 1'b0;
      if (abort_i) begin
        state      <= IDLE;
        in_ready_o <= 1'b0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state      <= SEND;
              pay_cnt    <= '0;
              in_ready_o <= 1'b1;
              busy_o     <= 1'b1;
            end
          end
          SEND: begin
            if (xfer) begin
              enc_en_o  <= 1'b1;
              enc_bit_o <= in_data_i;
              enc_pay   <= 1'b1;
              pay_cnt   <= pay_cnt + PAY_W'(1);
              if (pay_cnt == PAY_LAST) begin
                in_ready_o <= 1'b0;
                aux_cnt    <= '0;
                if (TAIL_LEN > 0) state <= TAIL;
                else              state <= DRAIN;
              end
            end
          end
          TAIL: begin
            enc_en_o <= 1'b1;
            aux_cnt  <= aux_cnt + AUX_W'(1);
            if (aux_cnt == TAIL_LAST) begin
              aux_cnt <= '0;
              state   <= DRAIN;
            end
          end
          DRAIN: begin
            aux_cnt <= aux_cnt + AUX_W'(1);
            if (aux_cnt == DRAIN_LAST) begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Reference pipeline: tags each encoder cycle so it meets its decoded bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      pipe_bit <= '0;
    end else if (abort_i) begin
      pipe_vld <= '0;
      pipe_bit <= '0;
    end else begin
      pipe_vld[0] <= enc_en_o & enc_pay;
      pipe_bit[0] <= enc_en_o & enc_pay & enc_bit_o;
      for (int unsigned i = 1; i < DEC_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_bit[i] <= pipe_bit[i-1];
      end
    end
  end

  // Saturating mismatch counter; cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (abort_i) begin
      err_cnt <= err_cnt;
    end else if (state == IDLE && start_i) begin
      err_cnt <= '0;
    end else if (mism && err_cnt != '1) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl (FRAME_LEN=8, TAIL_LEN=2,
// DEC_LAT=16). A loop-back decoder model replays enc_bit_o 16 cycles later,
// optionally inverting selected bits; a scoreboard queue holds expected
// encoder bits and results are compared at done_o.
module tb_viterbi_frame_ctrl;

  localparam int FL = 8;
  localparam int TL = 2;
  localparam int DL = 16;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic        in_valid_i;
  logic        in_data_i;
  logic        in_ready_o;
  logic        enc_bit_o;
  logic        enc_en_o;
  logic        dec_bit_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] err_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_q[$];

  viterbi_frame_ctrl #(
    .FRAME_LEN(FL),
    .TAIL_LEN (TL),
    .DEC_LAT  (DL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .in_valid_i(in_valid_i),
    .in_data_i (in_data_i),
    .in_ready_o(in_ready_o),
    .enc_bit_o (enc_bit_o),
    .enc_en_o  (enc_en_o),
    .dec_bit_i (dec_bit_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_cnt_o (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready_o, 0);
    chk({tag, "_en"},    enc_en_o,   0);
    chk({tag, "_bit"},   enc_bit_o,  0);
    chk({tag, "_busy"},  busy_o,     0);
    chk({tag, "_done"},  done_o,     0);
    chk({tag, "_err"},   err_cnt_o,  0);
  endtask

  // One frame, starting just after a rising edge. Cycle 0 carries start_i.
  // gap_lo..gap_hi: in_valid_i low; flip: invert decoded bit by enc_en index;
  // abort_at / rst_at / preload_at: cycle of that event (-1 = none);
  // exp_done: cycle of done_o (-1 = none expected).
  task automatic run_frame(input int gap_lo, input int gap_hi, input logic [15:0] flip,
                           input int abort_at, input int rst_at, input int preload_at,
                           input int exp_done, input logic [15:0] exp_err);
    int   pushed = 0;
    int   idx = 0;
    bit   saw_done = 0;
    bit   e;
    logic h_en[64];
    logic h_bit[64];
    int   h_idx[64];
    sb_q.delete();
    for (int c = 0; c < 40; c++) begin
      start_i    = (c == 0) || (c == 5);
      abort_i    = (c == abort_at);
      in_valid_i = !(c >= gap_lo && c <= gap_hi);
      in_data_i  = 1'($urandom_range(0, 1));
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        chk_reset_vals("rst_async");
      end
      @(negedge clk);
      if (c == rst_at) rst = 1'b1;
      if (in_ready_o && in_valid_i) begin
        sb_q.push_back(in_data_i);
        pushed++;
        if (pushed == FL) repeat (TL) sb_q.push_back(1'b0);
      end
      h_en[c]  = enc_en_o;
      h_bit[c] = enc_bit_o;
      h_idx[c] = idx;
      if (enc_en_o) begin
        if (sb_q.size() == 0) chk("enc_extra", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("enc_bit", enc_bit_o, e);
        end
        idx++;
      end else begin
        chk("enc_bit_idle", enc_bit_o, 0);
      end
      if (c > gap_lo && c <= gap_hi + 1) chk("gap_en", enc_en_o, 0);
      if (abort_at >= 0 && c > abort_at) begin
        chk("abort_busy", busy_o, 0);
        chk("abort_en", enc_en_o, 0);
      end
      if (rst_at >= 0 && c > rst_at) chk("rst_idle_busy", busy_o, 0);
      if (done_o) begin
        saw_done = 1;
        chk("done_cyc", c, exp_done);
        chk("err_at_done", err_cnt_o, exp_err);
      end
      if (c == preload_at) begin
        force dut.err_cnt = 16'hFFFF;
        #1;
        release dut.err_cnt;
      end
      if (c >= DL && h_en[c-DL])
        dec_bit_i = h_bit[c-DL] ^ ((h_idx[c-DL] < 16) ? flip[h_idx[c-DL]] : 1'b0);
      else
        dec_bit_i = 1'b0;
      @(posedge clk);
      #1;
    end
    start_i    = 1'b0;
    abort_i    = 1'b0;
    in_valid_i = 1'b0;
    dec_bit_i  = 1'b0;
    chk("done_seen", saw_done, (exp_done >= 0));
    if (exp_done >= 0) chk("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 1'b0;
    dec_bit_i  = 1'b0;
    #3;
    chk_reset_vals("reset");
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // clean frame
    run_frame(99, 98, 16'h0000, -1, -1, -1, 28, 16'd0);
    // payload bits 0 and 5 plus both tail bits inverted: tails never count
    run_frame(99, 98, 16'h0321, -1, -1, -1, 28, 16'd2);
    repeat (3) @(posedge clk);
    #1 chk("err_hold_idle", err_cnt_o, 16'd2);
    // in_valid_i stall for cycles 3-5
    run_frame(3, 5, 16'h0000, -1, -1, -1, 31, 16'd0);
    // abort at cycle 6, then a fresh start is accepted
    run_frame(99, 98, 16'h0001, 6, -1, -1, -1, 16'd0);
    run_frame(99, 98, 16'h0000, -1, -1, -1, 28, 16'd0);

    // abort and start together in IDLE: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start_busy", busy_o, 0);
    chk("abort_start_ready", in_ready_o, 0);

    // saturation: counter forced to all ones before two payload mismatches
    run_frame(99, 98, 16'h0021, -1, -1, 3, 28, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 chk("sat_hold_idle", err_cnt_o, 16'hFFFF);

    // asynchronous reset in IDLE clears a held count
    rst = 1'b0;
    #1 chk("rst_idle_err", err_cnt_o, 16'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // reset at cycle 9 of a frame, then a fresh frame after release
    run_frame(99, 98, 16'h0001, -1, 9, -1, -1, 16'd0);
    run_frame(99, 98, 16'h0004, -1, -1, -1, 28, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 64, payload bits per frame (>=1).
REQ-002 Parameter TAIL_LEN, default 2, zero flush bits appended per frame (>=0).
REQ-003 Parameter DEC_LAT, default 16, clock cycles from an encoder-enable cycle to the matching decoder output bit (>=1).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  request to begin a frame; sampled only in IDLE.
REQ-007 abort_i  in  1  synchronous abort of the current frame.
REQ-008 in_valid_i  in  1  payload bit offered.
REQ-009 in_data_i  in  1  payload bit value.
REQ-010 in_ready_o  out  1  controller accepts a payload bit this cycle.
REQ-011 enc_bit_o  out  1  bit to encoder d_in.
REQ-012 enc_en_o  out  1  encoder enable_i.
REQ-013 dec_bit_i  in  1  decoder d_out.
REQ-014 busy_o  out  1  high in any state other than IDLE.
REQ-015 done_o  out  1  one-cycle pulse at frame completion.
REQ-016 err_cnt_o  out  16  payload bit mismatches in current or last frame.

Function
REQ-017 States: IDLE, SEND, TAIL, DRAIN, DONE; registered state, one-hot or binary.
REQ-018 IDLE -> SEND on start_i=1; err_cnt_o and payload counter clear on that edge.
REQ-019 in_ready_o = 1 only in SEND; a transfer occurs when in_valid_i & in_ready_o.
REQ-020 Each transfer drives enc_en_o=1, enc_bit_o=in_data_i in the following cycle; non-transfer SEND cycles drive enc_en_o=0 (stalls allowed).
REQ-021 SEND -> TAIL on the FRAME_LEN-th transfer (TAIL_LEN=0: directly to DRAIN).
REQ-022 TAIL lasts exactly TAIL_LEN cycles; each produces enc_en_o=1, enc_bit_o=0 the following cycle; then -> DRAIN.
REQ-023 enc_bit_o holds 0 whenever enc_en_o=0.
REQ-024 Compare pipeline: DEC_LAT-deep shift register of {cmp_valid, ref_bit}, advanced every cycle, loaded with {1, bit} for payload enc_en_o cycles, {0, 0} for tail and idle cycles.
REQ-025 For an enc_en_o payload cycle t, dec_bit_i is compared with ref_bit at cycle t+DEC_LAT; mismatch increments err_cnt_o, visible at t+DEC_LAT+1.
REQ-026 Tail bits never increment err_cnt_o.
REQ-027 err_cnt_o saturates at 16'hFFFF.
REQ-028 DRAIN lasts until the last payload compare has updated err_cnt_o; DONE is entered exactly DEC_LAT+1 cycles after the last enc_en_o=1 cycle.
REQ-029 DONE lasts one cycle with done_o=1, then -> IDLE; err_cnt_o holds until next accepted start_i.
REQ-030 start_i outside IDLE is ignored.
REQ-031 abort_i=1 in any state: next state IDLE, compare pipeline cleared, enc_en_o=0 next cycle, no done_o pulse, err_cnt_o holds.
REQ-032 abort_i and start_i together in IDLE: abort wins, stay IDLE.
REQ-033 Payload counter width $clog2(FRAME_LEN+1); no wrap within a frame.

Reset
REQ-034 rst=0 asynchronously forces IDLE, clears compare pipeline and counters; in_ready_o=0, enc_en_o=0, enc_bit_o=0, busy_o=0, done_o=0, err_cnt_o=0.
REQ-035 rst asserted mid-frame discards the frame; after release the block waits in IDLE for start_i.

Verification (FRAME_LEN=8, TAIL_LEN=2, DEC_LAT=16, start_i at cycle 0)
REQ-036 Clean frame, in_valid_i always 1, dec_bit_i = enc_bit_o delayed 16 -> enc_en_o high cycles 2-11, bits 10-11 zero, done_o at cycle 28, err_cnt_o=0.
REQ-037 Same, dec_bit_i inverted for payload bits 0 and 5 and both tail bits -> err_cnt_o=2 at done_o.
REQ-038 in_valid_i low cycles 3-5 -> enc_en_o gaps at cycles 4-6, all compares still aligned, err_cnt_o=0, done_o at cycle 31.
REQ-039 abort_i at cycle 6 -> IDLE at cycle 7, enc_en_o=0 from cycle 7, no done_o; new start_i accepted next.
REQ-040 rst low at cycle 9 -> all outputs at reset values immediately; start_i during busy frame ignored; err_cnt_o saturation checked with forced 16'hFFFF preload.
